div_iter: RTL and testbench
===========================

# div_iter

Parametrised iterative restoring divider. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor at one quotient bit per clock. It uses a start/busy/done handshake and flags divide-by-zero. It is the general-width successor of the fixed 4-bit divider and sits beside the ALU as a multi-cycle execution unit.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clock  input  1  rising-edge clock, single domain
- reset  input  1  synchronous, active-high; dominates every other input
- start  input  1  request; accepted only when busy=0
- x  input  WIDTH  dividend; sampled on the accept cycle only
- y  input  WIDTH  divisor; sampled on the accept cycle only
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; q/r/error are valid from this cycle
- q  output  WIDTH  quotient; held until the next accepted start
- r  output  WIDTH  remainder; held until the next accepted start
- error  output  1  divide-by-zero flag for the last operation; held with q/r

## Operation
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start & y≠0 → RUN; capture operands, set counter=WIDTH, clear the partial remainder.
  - IDLE/DONE + start & y=0 → DONE.
  - RUN with counter=1 after a step → DONE.
  - DONE with no start → IDLE.
- RUN step:
  - Shift {partial remainder, dividend} left by one.
  - Trial-subtract the divisor in WIDTH+1 bits.
  - If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Decrement the counter.
- Results update only on entry to DONE. Between operations they hold the last values.
- Divide by zero: q = all ones, r = x, error = 1. The FSM does not enter RUN.
- A successful division clears error.
- start while busy=1 is ignored. There is no queueing and no abort input.
- start in DONE is accepted, giving back-to-back operation with no IDLE gap.
- Reset in any state (including mid-RUN):
  - next state IDLE
  - q=0, r=0, error=0, busy=0, done=0
  - counter and datapath registers cleared
  - a start in the same cycle as reset is dropped

## Timing
- Cycle 0 is the accept cycle (start=1, busy=0).
- Normal latency:
  - busy=1 in cycles 1..WIDTH
  - done=1 in cycle WIDTH+1, with q/r valid in that cycle
  - busy=0 in cycle WIDTH+1
- Divide-by-zero latency: done=1 in cycle 1; busy stays 0 throughout.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- Outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values: busy=0, done=0, q=0, r=0, error=0.

## Configuration
- DIV_SIGNED_EN defined: operands and results are two's-complement.
  - Magnitudes are taken on the accept cycle and the sign is corrected on entry to DONE, so latency is unchanged.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives q = most-negative, r = 0, error = 0.
  - Divide by zero still gives q = all ones, r = x.
- DIV_SIGNED_EN undefined: operands and results are unsigned. No sign logic is synthesised.

## Structure
- Shared package div_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the counter width function clog2(WIDTH+1)
  - the divide-by-zero quotient constant
- Sub-module div_step: combinational single restoring step, parametrised by WIDTH.
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: new partial remainder, quotient bit.
- div_iter instantiates one div_step and holds the FSM, counter, operand registers and output registers.

## Test plan
- WIDTH=4, x=15, y=2, start pulse after reset: done in cycle 5 with q=7, r=1, error=0; busy high in cycles 1–4.
- WIDTH=4, x=7, y=3 issued on the done cycle of the previous op: accepted, next done 5 cycles later with q=2, r=1.
- WIDTH=4, x=10, y=0: done in cycle 1 with q=15, r=10, error=1, busy never high; a following 9/3 gives q=3, r=0, error=0.
- WIDTH=8, x=200, y=7; pulse start again in cycle 3: second start ignored; done in cycle 9 with q=28, r=4.
- WIDTH=8, reset asserted in cycle 4 of a 255/1 division: all outputs 0 next cycle, state IDLE; a new 100/10 gives q=10, r=0.
- DIV_SIGNED_EN, WIDTH=8:
  - −7/2 gives q=−3, r=−1.
  - 7/−2 gives q=−3, r=1.
  - −128/−1 gives q=−128, r=0, error=0.

Source files
------------

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative restoring divider:
//   state_t    - FSM state encoding (IDLE, RUN, DONE)
//   MAX_WIDTH  - widest supported operand width
//   DIV0_Q     - divide-by-zero quotient pattern (all ones, sliced to WIDTH)
//   cnt_width  - width of the step counter, clog2(width+1)
// -----------------------------------------------------------------------------
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MAX_WIDTH = 32;

   localparam logic [MAX_WIDTH-1:0] DIV0_Q = '1;

   // The counter must hold the value WIDTH itself, hence width+1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step. The partial remainder is shifted
// left with the next dividend bit, the divisor is trial-subtracted in WIDTH+1
// bits, and the difference is kept only if it did not go negative.
//
// Ports:
//   i_rem      [WIDTH-1:0]  current partial remainder (always < divisor)
//   i_dvd_msb               dividend bit being shifted in
//   i_dvs      [WIDTH-1:0]  divisor
//   o_rem      [WIDTH-1:0]  new partial remainder
//   o_qbit                  quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_dvd_msb,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0] w_diff;

   assign w_diff = {i_rem, i_dvd_msb} - {1'b0, i_dvs};

   // Sign bit of the WIDTH+1 bit difference: 0 means the divisor fit.
   assign o_qbit = ~w_diff[WIDTH];

   // On restore the shifted value is below the divisor, so it fits in WIDTH
   // bits and the shifted-out MSB of i_rem is known to be zero.
   assign o_rem = o_qbit ? w_diff[WIDTH-1:0] : {i_rem[WIDTH-2:0], i_dvd_msb};

endmodule

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Parametrised iterative restoring divider, one quotient bit per clock.
// start/busy/done handshake, divide-by-zero flagged via error.
//
// Optional feature macro: DIV_SIGNED_EN
//   defined   - two's-complement operands and results; magnitudes are taken
//               on accept and signs corrected on entry to DONE (quotient
//               truncates toward zero, remainder follows the dividend sign).
//   undefined - unsigned operation, no sign logic.
//
// Ports:
//   clock               rising-edge clock
//   reset               synchronous active-high reset, dominates all inputs
//   start               request, accepted only while busy=0
//   x      [WIDTH-1:0]  dividend, sampled on accept
//   y      [WIDTH-1:0]  divisor, sampled on accept
//   busy                high while a division is running
//   done                one-cycle pulse when q/r/error are updated
//   q      [WIDTH-1:0]  quotient, held until the next accepted start
//   r      [WIDTH-1:0]  remainder, held until the next accepted start
//   error               divide-by-zero flag of the last operation
// -----------------------------------------------------------------------------
module div_iter
   import div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             error
);

   localparam int CW = cnt_width(WIDTH);

   if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("div_iter: WIDTH must be in 2..32");
   end

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;   // partial remainder
   logic [WIDTH-1:0] r_dvd;   // dividend shifting out MSB-first, quotient shifting in
   logic [WIDTH-1:0] r_dvs;   // divisor (magnitude in signed mode)
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_err;

   logic [WIDTH-1:0] w_rem_next;
   logic             w_qbit;
   logic [WIDTH-1:0] w_q_mag;
   logic [WIDTH-1:0] w_r_mag;
   logic [WIDTH-1:0] w_x_mag;
   logic [WIDTH-1:0] w_y_mag;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (r_rem),
      .i_dvd_msb (r_dvd[WIDTH-1]),
      .i_dvs     (r_dvs),
      .o_rem     (w_rem_next),
      .o_qbit    (w_qbit)
   );

   // Results as they will stand after the current (final) step.
   assign w_q_mag = {r_dvd[WIDTH-2:0], w_qbit};
   assign w_r_mag = w_rem_next;

`ifdef DIV_SIGNED_EN
   logic w_x_neg;
   logic w_y_neg;
   logic r_q_neg;
   logic r_r_neg;

   assign w_x_neg = x[WIDTH-1];
   assign w_y_neg = y[WIDTH-1];
   // The most-negative value maps onto itself, which read as unsigned is the
   // correct magnitude, so no extra width is needed.
   assign w_x_mag = w_x_neg ? -x : x;
   assign w_y_mag = w_y_neg ? -y : y;
   assign w_q_fin = r_q_neg ? -w_q_mag : w_q_mag;
   assign w_r_fin = r_r_neg ? -w_r_mag : w_r_mag;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_q_neg <= 1'b0;
         r_r_neg <= 1'b0;
      end else if (!r_busy && start && (y != '0)) begin
         r_q_neg <= w_x_neg ^ w_y_neg;
         r_r_neg <= w_x_neg;
      end
   end
`else
   assign w_x_mag = x;
   assign w_y_mag = y;
   assign w_q_fin = w_q_mag;
   assign w_r_fin = w_r_mag;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: datapath registers are cleared along with control so a reset
         // mid-RUN leaves no stale operand or remainder behind.
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_q     <= '0;
         r_r     <= '0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               r_state <= IDLE;
               if (start) begin
                  if (y != '0) begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                     r_cnt   <= CW'(WIDTH);
                     r_rem   <= '0;
                     r_dvd   <= w_x_mag;
                     r_dvs   <= w_y_mag;
                  end else begin
                     // Divide by zero resolves immediately, never entering RUN.
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_q     <= DIV0_Q[WIDTH-1:0];
                     r_r     <= x;
                     r_err   <= 1'b1;
                  end
               end
            end

            RUN: begin
               r_rem <= w_rem_next;
               r_dvd <= w_q_mag;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_q     <= w_q_fin;
                  r_r     <= w_r_fin;
                  r_err   <= 1'b0;
               end
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign q     = r_q;
   assign r     = r_r;
   assign error = r_err;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
// Directed self-checking bench for div_iter with one WIDTH=4 and one WIDTH=8
// instance. Inputs change 1 time unit after a rising edge; outputs are sampled
// at the same point, so "cycle N" below is the state after the Nth edge
// following the accept cycle.
// -----------------------------------------------------------------------------
module tb_div_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4, start4, busy4, done4, err4;
   logic [3:0] x4, y4, q4, r4;
   logic       rst8, start8, busy8, done8, err8;
   logic [7:0] x8, y8, q8, r8;

   int checks = 0;
   int errors = 0;

`ifdef DIV_SIGNED_EN
   localparam logic [3:0] EXP_15_2_Q  = 4'h0;   // -1 / 2
   localparam logic [3:0] EXP_15_2_R  = 4'hF;
   localparam logic [3:0] EXP_9_3_Q   = 4'hE;   // -7 / 3
   localparam logic [3:0] EXP_9_3_R   = 4'hF;
   localparam logic [7:0] EXP_200_7_Q = 8'hF8;  // -56 / 7
   localparam logic [7:0] EXP_200_7_R = 8'h00;
`else
   localparam logic [3:0] EXP_15_2_Q  = 4'd7;
   localparam logic [3:0] EXP_15_2_R  = 4'd1;
   localparam logic [3:0] EXP_9_3_Q   = 4'd3;
   localparam logic [3:0] EXP_9_3_R   = 4'd0;
   localparam logic [7:0] EXP_200_7_Q = 8'd28;
   localparam logic [7:0] EXP_200_7_R = 8'd4;
`endif

   div_iter #(.WIDTH(4)) u_d4 (
      .clock (clk), .reset (rst4), .start (start4), .x (x4), .y (y4),
      .busy (busy4), .done (done4), .q (q4), .r (r4), .error (err4)
   );

   div_iter #(.WIDTH(8)) u_d8 (
      .clock (clk), .reset (rst8), .start (start8), .x (x8), .y (y8),
      .busy (busy8), .done (done8), .q (q8), .r (r8), .error (err8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst4 = 1'b1; start4 = 1'b0; x4 = '0; y4 = '0;
      rst8 = 1'b1; start8 = 1'b0; x8 = '0; y8 = '0;
      repeat (3) tick();
      checks++;
      if ({busy4, done4, err4, q4, r4} !== 11'd0) begin
         errors++;
         $display("FAIL reset_w4: got busy=%b done=%b err=%b q=%0d r=%0d, want all 0", busy4, done4, err4, q4, r4);
      end
      checks++;
      if ({busy8, done8, err8, q8, r8} !== 19'd0) begin
         errors++;
         $display("FAIL reset_w8: got busy=%b done=%b err=%b q=%0d r=%0d, want all 0", busy8, done8, err8, q8, r8);
      end
      rst4 = 1'b0; rst8 = 1'b0;
      tick();
      checks++;
      if ({busy4, done4, busy8, done8} !== 4'd0) begin
         errors++;
         $display("FAIL idle_after_reset: got busy4=%b done4=%b busy8=%b done8=%b, want 0", busy4, done4, busy8, done8);
      end
   endtask

   // 15/2 started right after reset; leaves the bench in the done cycle.
   task automatic test_basic();
      start4 = 1'b1; x4 = 4'd15; y4 = 4'd2;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) start4 = 1'b0;
         checks++;
         if (busy4 !== (c <= 4) || done4 !== (c == 5)) begin
            errors++;
            $display("FAIL basic_hs c=%0d: got busy=%b done=%b, want busy=%b done=%b", c, busy4, done4, c <= 4, c == 5);
         end
      end
      checks++;
      if (q4 !== EXP_15_2_Q || r4 !== EXP_15_2_R || err4 !== 1'b0) begin
         errors++;
         $display("FAIL basic_15_2: got q=%0d r=%0d err=%b, want q=%0d r=%0d err=0", q4, r4, err4, EXP_15_2_Q, EXP_15_2_R);
      end
   endtask

   // 7/3 issued on the done cycle of the previous operation.
   task automatic test_back_to_back();
      start4 = 1'b1; x4 = 4'd7; y4 = 4'd3;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) start4 = 1'b0;
         checks++;
         if (busy4 !== (c <= 4) || done4 !== (c == 5)) begin
            errors++;
            $display("FAIL b2b_hs c=%0d: got busy=%b done=%b, want busy=%b done=%b", c, busy4, done4, c <= 4, c == 5);
         end
      end
      checks++;
      if (q4 !== 4'd2 || r4 !== 4'd1 || err4 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_7_3: got q=%0d r=%0d err=%b, want q=2 r=1 err=0", q4, r4, err4);
      end
      tick();
      checks++;
      if (done4 !== 1'b0 || busy4 !== 1'b0 || q4 !== 4'd2 || r4 !== 4'd1) begin
         errors++;
         $display("FAIL b2b_hold: got done=%b busy=%b q=%0d r=%0d, want done=0 busy=0 q=2 r=1", done4, busy4, q4, r4);
      end
   endtask

   task automatic test_div_zero();
      start4 = 1'b1; x4 = 4'd10; y4 = 4'd0;
      tick();
      start4 = 1'b0;
      checks++;
      if (done4 !== 1'b1 || busy4 !== 1'b0 || q4 !== 4'd15 || r4 !== 4'd10 || err4 !== 1'b1) begin
         errors++;
         $display("FAIL dz_result: got done=%b busy=%b q=%0d r=%0d err=%b, want done=1 busy=0 q=15 r=10 err=1", done4, busy4, q4, r4, err4);
      end
      tick();
      checks++;
      if (done4 !== 1'b0 || busy4 !== 1'b0 || q4 !== 4'd15 || err4 !== 1'b1) begin
         errors++;
         $display("FAIL dz_hold: got done=%b busy=%b q=%0d err=%b, want done=0 busy=0 q=15 err=1", done4, busy4, q4, err4);
      end
      start4 = 1'b1; x4 = 4'd9; y4 = 4'd3;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) start4 = 1'b0;
         checks++;
         if (busy4 !== (c <= 4) || done4 !== (c == 5)) begin
            errors++;
            $display("FAIL dz_next_hs c=%0d: got busy=%b done=%b, want busy=%b done=%b", c, busy4, done4, c <= 4, c == 5);
         end
      end
      checks++;
      if (q4 !== EXP_9_3_Q || r4 !== EXP_9_3_R || err4 !== 1'b0) begin
         errors++;
         $display("FAIL dz_next_9_3: got q=%0d r=%0d err=%b, want q=%0d r=%0d err=0", q4, r4, err4, EXP_9_3_Q, EXP_9_3_R);
      end
   endtask

   // 200/7 with a second start pulsed in cycle 3 while busy.
   task automatic test_ignore_start();
      start8 = 1'b1; x8 = 8'd200; y8 = 8'd7;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1) start8 = 1'b0;
         if (c == 3) begin start8 = 1'b1; x8 = 8'd50; y8 = 8'd5; end
         if (c == 4) start8 = 1'b0;
         checks++;
         if (busy8 !== (c <= 8) || done8 !== (c == 9)) begin
            errors++;
            $display("FAIL ign_hs c=%0d: got busy=%b done=%b, want busy=%b done=%b", c, busy8, done8, c <= 8, c == 9);
         end
      end
      checks++;
      if (q8 !== EXP_200_7_Q || r8 !== EXP_200_7_R || err8 !== 1'b0) begin
         errors++;
         $display("FAIL ign_200_7: got q=%0d r=%0d err=%b, want q=%0d r=%0d err=0", q8, r8, err8, EXP_200_7_Q, EXP_200_7_R);
      end
      for (int c = 10; c <= 11; c++) begin
         tick();
         checks++;
         if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL ign_no_queue c=%0d: got busy=%b done=%b, want 0 0", c, busy8, done8);
         end
      end
   endtask

   // Reset in cycle 4 of 255/1, with a start in the reset cycle that must drop.
   task automatic test_reset_mid();
      start8 = 1'b1; x8 = 8'd255; y8 = 8'd1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) start8 = 1'b0;
      end
      rst8 = 1'b1; start8 = 1'b1; x8 = 8'd100; y8 = 8'd10;
      tick();
      checks++;
      if ({busy8, done8, err8, q8, r8} !== 19'd0) begin
         errors++;
         $display("FAIL midrst_outs: got busy=%b done=%b err=%b q=%0d r=%0d, want all 0", busy8, done8, err8, q8, r8);
      end
      rst8 = 1'b0; start8 = 1'b0;
      tick();
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL midrst_start_dropped: got busy=%b done=%b, want 0 0", busy8, done8);
      end
      start8 = 1'b1; x8 = 8'd100; y8 = 8'd10;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1) start8 = 1'b0;
         checks++;
         if (busy8 !== (c <= 8) || done8 !== (c == 9)) begin
            errors++;
            $display("FAIL midrst_next_hs c=%0d: got busy=%b done=%b, want busy=%b done=%b", c, busy8, done8, c <= 8, c == 9);
         end
      end
      checks++;
      if (q8 !== 8'd10 || r8 !== 8'd0 || err8 !== 1'b0) begin
         errors++;
         $display("FAIL midrst_100_10: got q=%0d r=%0d err=%b, want q=10 r=0 err=0", q8, r8, err8);
      end
   endtask

   // Back-to-back table of vectors with {x, y, q, r}; a single stream of
   // starts issued on each done cycle.
   task automatic run_table8(input string name, input logic [31:0] vec [], input int n);
      for (int i = 0; i < n; i++) begin
         start8 = 1'b1; x8 = vec[i][31:24]; y8 = vec[i][23:16];
         for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) start8 = 1'b0;
         end
         checks++;
         if (done8 !== 1'b1 || q8 !== vec[i][15:8] || r8 !== vec[i][7:0] || err8 !== 1'b0) begin
            errors++;
            $display("FAIL %s[%0d] %0h/%0h: got done=%b q=%0h r=%0h err=%b, want done=1 q=%0h r=%0h err=0",
                     name, i, vec[i][31:24], vec[i][23:16], done8, q8, r8, err8, vec[i][15:8], vec[i][7:0]);
         end
      end
      tick();
   endtask

   // Values chosen to give identical results in signed and unsigned builds.
   task automatic test_boundaries();
      logic [31:0] vec [];
      vec = new[5];
      vec[0] = {8'd255, 8'd255, 8'd1,   8'd0};
      vec[1] = {8'd5,   8'd9,   8'd0,   8'd5};
      vec[2] = {8'd0,   8'd7,   8'd0,   8'd0};
      vec[3] = {8'd128, 8'd1,   8'd128, 8'd0};
      vec[4] = {8'd127, 8'd127, 8'd1,   8'd0};
      run_table8("bound", vec, 5);
   endtask

`ifdef DIV_SIGNED_EN
   task automatic test_signed();
      logic [31:0] vec [];
      vec = new[4];
      vec[0] = {8'hF9, 8'h02, 8'hFD, 8'hFF};   // -7 / 2  = -3 r -1
      vec[1] = {8'h07, 8'hFE, 8'hFD, 8'h01};   //  7 / -2 = -3 r  1
      vec[2] = {8'h80, 8'hFF, 8'h80, 8'h00};   // -128 / -1 = -128 r 0
      vec[3] = {8'hF9, 8'hFE, 8'h03, 8'hFF};   // -7 / -2 =  3 r -1
      run_table8("signed", vec, 4);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_boundaries();
`ifdef DIV_SIGNED_EN
      test_signed();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
